rv_to_axi_master: RTL and testbench
===================================

RV_TO_AXI_MASTER -- requirements
Module: rv_to_axi_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning AXI4-Lite address width.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, meaning watchdog limit in clocks (used only with RV_TO_AXI_MASTER_TIMEOUT_EN).
REQ-003 SHALL have one clock and an asynchronous active-low reset: M00_AXI_aclk  in  1  clock; M00_AXI_aresetn  in  1  async active-low reset.
REQ-004 SHALL have command ports: cmd_valid_i  in  1  command offered; cmd_ready_o  out  1  command accepted; cmd_write_i  in  1  1=write 0=read; cmd_addr_i  in  ADDR_W  target address; cmd_wdata_i  in  32  write data.
REQ-005 SHALL have response ports: rsp_valid_o  out  1  response offered; rsp_ready_i  in  1  response taken; rsp_rdata_o  out  32  read data (0 for writes); rsp_error_o  out  1  1 if resp!=OKAY or timeout.
REQ-006 SHALL have AXI4-Lite master ports M00_AXI_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready, with AXI-standard directions and widths; awprot/arprot are not implemented.

Function
REQ-007 SHALL hold one transaction at a time; FSM states IDLE, WR, WRESP, RD, RRESP, RSP.
REQ-008 cmd_ready_o SHALL be 1 only in IDLE; command is accepted on the cycle where cmd_valid_i & cmd_ready_o; address/data SHALL be captured into registers at that edge.
REQ-009 On an accepted write: next state WR; awvalid and wvalid SHALL both assert from the following cycle; wstrb SHALL be 4'hF.
REQ-010 In WR each of awvalid and wvalid SHALL deassert independently after its own handshake; the FSM SHALL move to WRESP once both handshakes have occurred, in either order or in the same cycle.
REQ-011 In WRESP bready SHALL be 1; on bvalid it SHALL latch error=(bresp!=2'b00), set rdata=0, and go to RSP.
REQ-012 On an accepted read: next state RD; arvalid SHALL assert from the following cycle until arready; then RRESP with rready=1; on rvalid it SHALL latch rdata and error=(rresp!=2'b00), then go to RSP.
REQ-013 In RSP rsp_valid_o SHALL be 1 with stable data until rsp_ready_i; then IDLE; rsp_valid_o SHALL NOT depend combinationally on rsp_ready_i.
REQ-014 All AXI valid/ready outputs SHALL be registered; address/data outputs SHALL be stable while the corresponding valid is high.
REQ-015 Minimum latency: command accept at edge N, response valid at edge N+3 when the slave answers with zero wait states.
REQ-016 Back-to-back: a new command SHALL be acceptable on the cycle following the response handshake.

Reset
REQ-017 Asserting M00_AXI_aresetn low SHALL, asynchronously, force state IDLE and all valid/ready outputs to 0 except cmd_ready_o, which SHALL read 1 after reset release; rsp_rdata_o=0, rsp_error_o=0.
REQ-018 Reset mid-transaction SHALL abandon the transaction without issuing a response.

Configuration
REQ-019 With RV_TO_AXI_MASTER_TIMEOUT_EN defined, a counter SHALL run in WR/WRESP/RD/RRESP; reaching TIMEOUT_CYC SHALL drop all AXI valids/readies and enter RSP with rsp_error_o=1 and rsp_rdata_o=32'hDEAD_DEAD; without it the block SHALL wait indefinitely and contain no counter.

Structure
REQ-020 Package rv_axi_pkg SHALL hold the FSM state typedef and the constants RESP_OKAY=2'b00 and TIMEOUT_RDATA=32'hDEAD_DEAD.
REQ-021 The watchdog SHALL be a sub-module rv_axi_timeout (clk, resetn, run, expired), instantiated only under the macro.

Verification
REQ-022 Write addr 0x0, data 0xDEADBEEF, slave accepts aw at cycle +3 and w at +1, bresp=OKAY -> exactly one aw and one w handshake, rsp_valid_o=1, rsp_error_o=0, rsp_rdata_o=0.
REQ-023 Read addr 0x4, slave returns rdata 0x12345678, rresp=OKAY after 5 wait cycles -> rsp_rdata_o=0x12345678, rsp_error_o=0.
REQ-024 Read with rresp=SLVERR (2'b10) -> rsp_error_o=1; rsp_ready_i held 0 for 4 cycles -> response held stable, cmd_ready_o=0 throughout.
REQ-025 Write with awready and wready asserted in the same cycle and zero-wait bvalid -> rsp_valid_o at N+3; a second command is accepted the cycle after the response handshake.
REQ-026 Reset asserted in RRESP -> all AXI valids and rsp_valid_o immediately 0; after release cmd_ready_o=1 and no stale response appears.
REQ-027 With macro defined and TIMEOUT_CYC=16, slave never asserts arready -> arvalid drops and rsp_error_o=1, rsp_rdata_o=0xDEADDEAD within 18 cycles of command accept.

Source files
------------

// File: rtl/rv_axi_pkg.sv
// Shared types and constants for the RV command to AXI4-Lite master bridge.
package rv_axi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        WRESP = 3'd2,
        RD    = 3'd3,
        RRESP = 3'd4,
        RSP   = 3'd5
    } state_t;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;

endpackage

// File: rtl/rv_to_axi_master_if.sv
// AXI4-Lite bus bundle (no prot signals) with master and slave views.
interface rv_to_axi_master_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/rv_to_axi_master_timeout.sv
// Watchdog for rv_to_axi_master: counts cycles while run is high and flags expiry.
module rv_axi_timeout #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    // Saturates at the limit; cleared whenever the master leaves its busy states.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (cnt != CW'(TIMEOUT_CYC)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = run && (cnt == CW'(TIMEOUT_CYC));

endmodule

// File: rtl/rv_to_axi_master.sv
// Single-outstanding command/response to AXI4-Lite master bridge.
// Optional watchdog enabled by defining RV_TO_AXI_MASTER_TIMEOUT_EN.
module rv_to_axi_master
    import rv_axi_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                M00_AXI_aclk,
    input  logic                M00_AXI_aresetn,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [31:0]         cmd_wdata_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [31:0]         rsp_rdata_o,
    output logic                rsp_error_o,
    rv_to_axi_master_if.master  M00_AXI
);
    if (TIMEOUT_CYC < 1) begin : g_param_check
        $error("rv_to_axi_master: TIMEOUT_CYC must be at least 1");
    end

    state_t            state_q, state_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              load;

`ifdef RV_TO_AXI_MASTER_TIMEOUT_EN
    logic run;
    logic expired;

    assign run = (state_q == WR) || (state_q == WRESP) || (state_q == RD) || (state_q == RRESP);

    rv_axi_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (M00_AXI_aclk),
        .resetn (M00_AXI_aresetn),
        .run    (run),
        .expired(expired)
    );
`endif

    always_ff @(posedge M00_AXI_aclk or negedge M00_AXI_aresetn) begin
        if (!M00_AXI_aresetn) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
            if (load) begin
                addr_q  <= cmd_addr_i;
                wdata_q <= cmd_wdata_i;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    load = 1'b1;
                    if (cmd_write_i) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                // A low valid here means that channel's handshake already happened.
                if (awvalid_q && M00_AXI.awready) awvalid_d = 1'b0;
                if (wvalid_q && M00_AXI.wready)   wvalid_d  = 1'b0;
                if ((!awvalid_q || M00_AXI.awready) && (!wvalid_q || M00_AXI.wready)) begin
                    state_d  = WRESP;
                    bready_d = 1'b1;
                end
            end
            WRESP: begin
                if (M00_AXI.bvalid) begin
                    bready_d = 1'b0;
                    rdata_d  = '0;
                    error_d  = (M00_AXI.bresp != RESP_OKAY);
                    state_d  = RSP;
                end
            end
            RD: begin
                if (M00_AXI.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RRESP;
                end
            end
            RRESP: begin
                if (M00_AXI.rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = M00_AXI.rdata;
                    error_d  = (M00_AXI.rresp != RESP_OKAY);
                    state_d  = RSP;
                end
            end
            RSP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef RV_TO_AXI_MASTER_TIMEOUT_EN
        if (expired) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            rdata_d   = TIMEOUT_RDATA;
            error_d   = 1'b1;
            state_d   = RSP;
        end
`endif
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RSP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_error_o = error_q;

    assign M00_AXI.awaddr  = addr_q;
    assign M00_AXI.awvalid = awvalid_q;
    assign M00_AXI.wdata   = wdata_q;
    assign M00_AXI.wstrb   = '1;
    assign M00_AXI.wvalid  = wvalid_q;
    assign M00_AXI.bready  = bready_q;
    assign M00_AXI.araddr  = addr_q;
    assign M00_AXI.arvalid = arvalid_q;
    assign M00_AXI.rready  = rready_q;

endmodule

// File: tb/tb_rv_to_axi_master.sv
// Self-checking bench for rv_to_axi_master: directed cases plus randomized transactions.
module tb_rv_to_axi_master;

    localparam int ADDR_W = 4;
    localparam int TCYC   = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [31:0]       cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;

    always #5 clk = ~clk;

    rv_to_axi_master_if #(.ADDR_W(ADDR_W)) bus ();

    rv_to_axi_master #(
        .ADDR_W     (ADDR_W),
        .TIMEOUT_CYC(TCYC)
    ) dut (
        .M00_AXI_aclk   (clk),
        .M00_AXI_aresetn(rst_n),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_write_i    (cmd_write),
        .cmd_addr_i     (cmd_addr),
        .cmd_wdata_i    (cmd_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_error_o    (rsp_error),
        .M00_AXI        (bus)
    );

    // Slave behaviour knobs: wait cycles per channel and the response to return.
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
    logic [31:0] s_rdata = '0;

    int              aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    int              n_aw = 0, n_w = 0, n_ar = 0;
    logic            aw_got, w_got, ar_got;
    logic [ADDR_W-1:0] cap_awaddr, cap_araddr;
    logic [31:0]     cap_wdata;
    logic [3:0]      cap_wstrb;

    assign bus.awready = bus.awvalid && (aw_cnt >= aw_dly);
    assign bus.wready  = bus.wvalid  && (w_cnt  >= w_dly);
    assign bus.arready = bus.arvalid && (ar_cnt >= ar_dly);
    assign bus.bresp   = s_bresp;
    assign bus.rresp   = s_rresp;

    always @(posedge clk or negedge rst_n) begin : slave
        logic aw_hs, w_hs, ar_hs;
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            bus.bvalid <= 1'b0; bus.rvalid <= 1'b0; bus.rdata <= '0;
        end else begin
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            ar_hs = bus.arvalid && bus.arready;
            if (aw_hs) begin
                n_aw <= n_aw + 1; cap_awaddr <= bus.awaddr; aw_cnt <= 0;
            end else if (bus.awvalid) aw_cnt <= aw_cnt + 1;
            if (w_hs) begin
                n_w <= n_w + 1; cap_wdata <= bus.wdata; cap_wstrb <= bus.wstrb; w_cnt <= 0;
            end else if (bus.wvalid) w_cnt <= w_cnt + 1;
            if (ar_hs) begin
                n_ar <= n_ar + 1; cap_araddr <= bus.araddr; ar_cnt <= 0;
            end else if (bus.arvalid) ar_cnt <= ar_cnt + 1;

            if (bus.bvalid && bus.bready) begin
                bus.bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
            end else if (!bus.bvalid && (aw_got || aw_hs) && (w_got || w_hs)) begin
                aw_got <= 1'b1; w_got <= 1'b1;
                if (b_cnt >= b_dly) bus.bvalid <= 1'b1;
                else b_cnt <= b_cnt + 1;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end

            if (bus.rvalid && bus.rready) begin
                bus.rvalid <= 1'b0; ar_got <= 1'b0; r_cnt <= 0;
            end else if (!bus.rvalid && (ar_got || ar_hs)) begin
                ar_got <= 1'b1;
                if (r_cnt >= r_dly) begin
                    bus.rvalid <= 1'b1; bus.rdata <= s_rdata;
                end else r_cnt <= r_cnt + 1;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one command at a negedge, check the response against the reference
    // expectations, hold rsp_ready low for 'hold' cycles, then take the response.
    task automatic do_txn(input bit wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                          input int awd, input int wdd, input int bd, input int ard, input int rd,
                          input logic [1:0] resp, input logic [31:0] rdat, input int hold);
        int          k, lat, exp_lat, aw0, w0, ar0;
        logic [31:0] exp_rdata;
        logic        exp_err;
        aw_dly = awd; w_dly = wdd; b_dly = bd; ar_dly = ard; r_dly = rd;
        s_bresp = resp; s_rresp = resp; s_rdata = rdat;
        exp_rdata = wr ? 32'h0 : rdat;
        exp_err   = (resp != 2'b00);
        exp_lat   = wr ? 3 + ((awd > wdd) ? awd : wdd) + bd : 3 + ard + rd;
        aw0 = n_aw; w0 = n_w; ar0 = n_ar;

        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk); k++;
        end
        check("accept_wait", 32'(k), 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_addr = ADDR_W'($urandom); cmd_wdata = $urandom;

        lat = 0;
        do begin
            @(negedge clk); lat++;
        end while (!rsp_valid && lat < 200);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_error", 32'(rsp_error), 32'(exp_err));
        check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
        if (wr) begin
            check("aw_count", 32'(n_aw - aw0), 32'd1);
            check("w_count", 32'(n_w - w0), 32'd1);
            check("ar_count_wr", 32'(n_ar - ar0), 32'd0);
            check("awaddr", 32'(cap_awaddr), 32'(addr));
            check("wdata", cap_wdata, wd);
            check("wstrb", 32'(cap_wstrb), 32'hF);
        end else begin
            check("ar_count", 32'(n_ar - ar0), 32'd1);
            check("aw_count_rd", 32'(n_aw - aw0), 32'd0);
            check("araddr", 32'(cap_araddr), 32'(addr));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, exp_rdata);
            check("hold_error", 32'(rsp_error), 32'(exp_err));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_error", 32'(rsp_error), 32'd0);
        check("rst_axi_valids", 32'({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        do_txn(1'b1, 4'h0, 32'hDEADBEEF, 3, 1, 0, 0, 0, 2'b00, 32'h0, 0);
        do_txn(1'b0, 4'h4, 32'h0, 0, 0, 0, 0, 5, 2'b00, 32'h12345678, 0);
        do_txn(1'b0, 4'h8, 32'h0, 0, 0, 0, 1, 2, 2'b10, 32'hCAFE0001, 4);
        do_txn(1'b1, 4'hC, 32'hA5A5_5A5A, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
        do_txn(1'b1, 4'h3, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 2'b11, 32'h0, 0);

        // Reset while waiting for the read data.
        aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 1000;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h5;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !bus.rready; i++) @(negedge clk);
        check("reached_rresp", 32'(bus.rready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_axi_valids", 32'({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}), 32'd0);
        check("async_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        r_dly = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("no_stale_rsp", 32'(seen), 32'd0);
        check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_reset_error", 32'(rsp_error), 32'd0);

        for (int t = 0; t < 24; t++) begin
            do_txn(1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom,
                   $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                   $urandom_range(0, 4), $urandom_range(0, 4),
                   2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3));
        end

`ifdef RV_TO_AXI_MASTER_TIMEOUT_EN
        begin
            int lat;
            ar_dly = 100000;
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h7;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            lat = 0;
            do begin
                @(negedge clk); lat++;
            end while (!rsp_valid && lat < 40);
            check("to_within_18", 32'(lat <= 18), 32'd1);
            check("to_arvalid", 32'(bus.arvalid), 32'd0);
            check("to_error", 32'(rsp_error), 32'd1);
            check("to_rdata", rsp_rdata, 32'hDEAD_DEAD);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check("to_cmd_ready", 32'(cmd_ready), 32'd1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
